// File: rtl/drum_access_sequencer_if.sv
// ---------------------------------------------------------------------------
// drum_access_sequencer_if
//   Bundles the drum timing tracks, the two requester ports and the drum
//   control outputs of the drum access sequencer.
//   slave  : view used by the sequencer (tracks/requests in, control out)
//   master : view used by the drum model and requesters driving the sequencer
//   Signals:
//     Z2, Z3, W1           word-marker track, sector-address track, drum ready
//     REQx/TRKx/ADRx/WRx   per-requester request level, track, word, direction
//     GNTx, DONE, ERR      grant, completion pulse, completion status
//     TRACK                head select
//     RD_GATE, WR_GATE     transfer gates
//     BITIDX, LOCK         bit index within word, word timing synchronised
// ---------------------------------------------------------------------------
interface drum_access_sequencer_if;
   logic       Z2;
   logic       Z3;
   logic       W1;
   logic       REQ0;
   logic       REQ1;
   logic [4:0] TRK0;
   logic [4:0] TRK1;
   logic [6:0] ADR0;
   logic [6:0] ADR1;
   logic       WR0;
   logic       WR1;
   logic       GNT0;
   logic       GNT1;
   logic       DONE;
   logic       ERR;
   logic [4:0] TRACK;
   logic       RD_GATE;
   logic       WR_GATE;
   logic [5:0] BITIDX;
   logic       LOCK;

   modport slave (
      input  Z2, Z3, W1, REQ0, REQ1, TRK0, TRK1, ADR0, ADR1, WR0, WR1,
      output GNT0, GNT1, DONE, ERR, TRACK, RD_GATE, WR_GATE, BITIDX, LOCK
   );

   modport master (
      output Z2, Z3, W1, REQ0, REQ1, TRK0, TRK1, ADR0, ADR1, WR0, WR1,
      input  GNT0, GNT1, DONE, ERR, TRACK, RD_GATE, WR_GATE, BITIDX, LOCK
   );
endinterface

// File: rtl/drum_access_sequencer.sv
// ---------------------------------------------------------------------------
// drum_access_sequencer
//   Recovers word timing from the drum marker track, tracks the sector
//   address of the word coming under the heads, arbitrates two requesters
//   round-robin and gates one 40-bit word transfer per granted access.
//   Ports:
//     Z1   bit clock, one rising edge per drum bit time
//     CLR  asynchronous active-low clear
//     bus  drum_access_sequencer_if.slave (tracks, requests, drum control)
//   BITIDX names the drum bit sampled on the most recent Z1 edge.
// ---------------------------------------------------------------------------
module drum_access_sequencer (
   input  logic                          Z1,
   input  logic                          CLR,
   drum_access_sequencer_if.slave        bus
);

   localparam logic [5:0] LAST_BIT     = 6'd39;
   localparam logic [5:0] SECT_FIRST   = 6'd32;
   localparam logic [5:0] SECT_LAST    = 6'd38;
   localparam logic [7:0] TIMEOUT_LAST = 8'd128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEEK   = 2'd1,
      XFER   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] run_q, run_d;
   logic [5:0] phase_q, phase_d;
   logic       lock_q, lock_d;
   logic [6:0] sector_q, sector_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       pri_q, pri_d;
   logic [4:0] trk_q, trk_d;
   logic [6:0] adr_q, adr_d;
   logic       wr_q, wr_d;
   logic [7:0] to_q, to_d;
   logic       err_q, err_d;
   logic       word_start;

   // Marker track ends each word with exactly two high bits (38-39); the
   // three-bit run at 31-33 is rejected by requiring a run length of 2.
   assign word_start = !bus.Z2 && (run_q == 2'd2);

   always_comb begin
      run_d    = run_q;
      phase_d  = phase_q;
      lock_d   = lock_q;
      sector_d = sector_q;

      if (bus.Z2) begin
         run_d = (run_q == 2'd3) ? run_q : run_q + 2'd1;
      end else begin
         run_d = 2'd0;
      end

      if (word_start) begin
         phase_d = 6'd0;
         // Unlocked: any start acquires lock. Locked: a start that does not
         // follow bit 39 means slipped timing, so drop lock and resync.
         lock_d  = lock_q ? (phase_q == LAST_BIT) : 1'b1;
      end else if (phase_q == LAST_BIT) begin
         phase_d = 6'd0;
      end else begin
         phase_d = phase_q + 6'd1;
      end

      // Bit being sampled now is phase_d; address arrives LSB first.
      if ((phase_d >= SECT_FIRST) && (phase_d <= SECT_LAST)) begin
         sector_d = {bus.Z3, sector_q[6:1]};
      end
   end

   always_comb begin
      state_d = state_q;
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      pri_d   = pri_q;
      trk_d   = trk_q;
      adr_d   = adr_q;
      wr_d    = wr_q;
      to_d    = to_q;
      err_d   = err_q;

      unique case (state_q)
         IDLE: begin
            // pri_q = 0 favours requester 0 on a tie, 1 favours requester 1.
            if (bus.REQ0 && (!bus.REQ1 || !pri_q)) begin
               gnt0_d  = 1'b1;
               trk_d   = bus.TRK0;
               adr_d   = bus.ADR0;
               wr_d    = bus.WR0;
               to_d    = 8'd0;
               err_d   = 1'b0;
               state_d = SEEK;
            end else if (bus.REQ1) begin
               gnt1_d  = 1'b1;
               trk_d   = bus.TRK1;
               adr_d   = bus.ADR1;
               wr_d    = bus.WR1;
               to_d    = 8'd0;
               err_d   = 1'b0;
               state_d = SEEK;
            end
         end

         SEEK: begin
            // At bit 39 the sector register names the word starting next.
            if (phase_q == LAST_BIT) begin
               if (lock_q && (sector_q == adr_q)) begin
                  if (wr_q && !bus.W1) begin
                     err_d   = 1'b1;
                     state_d = FINISH;
                  end else begin
                     state_d = XFER;
                  end
               end else if (to_q == TIMEOUT_LAST) begin
                  err_d   = 1'b1;
                  state_d = FINISH;
               end else begin
                  to_d = to_q + 8'd1;
               end
            end
         end

         XFER: begin
            if (!lock_q) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end else if (phase_q == LAST_BIT) begin
               err_d   = 1'b0;
               state_d = FINISH;
            end
         end

         FINISH: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            pri_d   = gnt0_q;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Z1 or negedge CLR) begin
      if (!CLR) begin
         state_q  <= IDLE;
         run_q    <= 2'd0;
         phase_q  <= 6'd0;
         lock_q   <= 1'b0;
         sector_q <= 7'd0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         pri_q    <= 1'b0;
         trk_q    <= 5'd0;
         to_q     <= 8'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         phase_q  <= phase_d;
         lock_q   <= lock_d;
         sector_q <= sector_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         pri_q    <= pri_d;
         trk_q    <= trk_d;
         to_q     <= to_d;
         err_q    <= err_d;
      end
   end

   // Latched request payload; only meaningful while a grant is held.
   always_ff @(posedge Z1) begin
      adr_q <= adr_d;
      wr_q  <= wr_d;
   end

   assign bus.GNT0    = gnt0_q;
   assign bus.GNT1    = gnt1_q;
   assign bus.DONE    = (state_q == FINISH);
   assign bus.ERR     = (state_q == FINISH) && err_q;
   assign bus.TRACK   = trk_q;
   // Gates are qualified by lock so a lost lock stops the transfer at once.
   assign bus.RD_GATE = (state_q == XFER) && lock_q && !wr_q;
   assign bus.WR_GATE = (state_q == XFER) && lock_q && wr_q;
   assign bus.BITIDX  = phase_q;
   assign bus.LOCK    = lock_q;

endmodule

// File: tb/tb_drum_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_drum_access_sequencer
//   Drum model (marker and sector tracks) plus directed requester stimulus
//   for drum_access_sequencer.
// ---------------------------------------------------------------------------
module tb_drum_access_sequencer;

   logic Z1;
   logic CLR;
   drum_access_sequencer_if bus ();

   drum_access_sequencer dut (
      .Z1  (Z1),
      .CLR (CLR),
      .bus (bus)
   );

   initial Z1 = 1'b0;
   always #5 Z1 = ~Z1;

   int   checks;
   int   errors;
   int   excl_viol;
   int   cur_bit, cur_word, smp_bit, smp_word;
   logic z3_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic drive_drum();
      logic [6:0] nxt;
      nxt = 7'((cur_word + 1) % 128);
      bus.Z2 = ((cur_bit >= 31) && (cur_bit <= 33)) || (cur_bit >= 38);
      if (z3_bad) bus.Z3 = 1'b1;
      else if ((cur_bit >= 32) && (cur_bit <= 38)) bus.Z3 = nxt[cur_bit - 32];
      else bus.Z3 = 1'b0;
   endtask

   // Drum rotates freely; smp_* name the bit the DUT sampled on the last edge.
   initial begin
      z3_bad   = 1'b0;
      cur_bit  = 5;
      cur_word = 100;
      smp_bit  = -1;
      smp_word = -1;
      drive_drum();
      forever begin
         @(posedge Z1);
         #1;
         smp_bit  = cur_bit;
         smp_word = cur_word;
         if (cur_bit == 39) begin
            cur_bit  = 0;
            cur_word = (cur_word + 1) % 128;
         end else begin
            cur_bit++;
         end
         drive_drum();
      end
   end

   initial excl_viol = 0;
   always @(negedge Z1) begin
      if ((bus.GNT0 && bus.GNT1) || (bus.RD_GATE && bus.WR_GATE)) excl_viol++;
   end

   task automatic watch_access(input int budget, output int rd_n, output int wr_n,
                               output int first_bit, output int first_word,
                               output int done_bit, output int done_word,
                               output int words, output logic err_v, output logic seen);
      rd_n = 0; wr_n = 0; first_bit = -1; first_word = -1;
      done_bit = -1; done_word = -1; words = 0; err_v = 1'b0; seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge Z1);
         if (smp_bit == 0) words++;
         if ((bus.RD_GATE || bus.WR_GATE) && (first_bit < 0)) begin
            first_bit  = smp_bit;
            first_word = smp_word;
         end
         if (bus.RD_GATE) rd_n++;
         if (bus.WR_GATE) wr_n++;
         if (bus.DONE) begin
            seen      = 1'b1;
            err_v     = bus.ERR;
            done_bit  = smp_bit;
            done_word = smp_word;
         end
      end
   endtask

   task automatic wait_lock(input int budget, output logic got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge Z1);
         if (bus.LOCK) got = 1'b1;
      end
   endtask

   initial begin
      int   rd_n, wr_n, fb, fw, db, dw, words, bad, dn, early;
      logic err_v, seen, got;

      checks = 0;
      errors = 0;
      CLR = 1'b0;
      bus.W1 = 1'b1;
      bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
      bus.TRK0 = 5'd0; bus.TRK1 = 5'd0;
      bus.ADR0 = 7'd0; bus.ADR1 = 7'd0;
      bus.WR0 = 1'b0;  bus.WR1 = 1'b0;

      // Reset state
      repeat (3) @(negedge Z1);
      check("rst_ctrl", {bus.GNT0, bus.GNT1, bus.DONE, bus.ERR, bus.RD_GATE, bus.WR_GATE, bus.LOCK}, 0);
      check("rst_track", bus.TRACK, 0);
      check("rst_bitidx", bus.BITIDX, 0);
      CLR = 1'b1;

      // Word sync
      wait_lock(200, got);
      check("sync_lock", got, 1);
      check("sync_at_bit0", smp_bit, 0);
      check("sync_bitidx", bus.BITIDX, 0);
      bad = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge Z1);
         if ((bus.BITIDX != 6'(smp_bit)) || !bus.LOCK) bad++;
      end
      check("sync_track", bad, 0);

      // Arbitration: simultaneous request, round-robin on repeat
      bus.TRK0 = 5'd1; bus.TRK1 = 5'd2;
      bus.ADR0 = 7'((smp_word + 3) % 128);
      bus.ADR1 = 7'((smp_word + 5) % 128);
      bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
      @(negedge Z1);
      check("arb1_gnt", {bus.GNT0, bus.GNT1}, 2'b10);
      check("arb1_track", bus.TRACK, 1);
      watch_access(6000, rd_n, wr_n, fb, fw, db, dw, words, err_v, seen);
      check("arb1_done", seen, 1);
      check("arb1_rd40", rd_n, 40);
      bus.ADR0 = 7'((smp_word + 3) % 128);
      @(negedge Z1);
      check("arb_gap", {bus.GNT0, bus.GNT1, bus.DONE}, 3'b000);
      @(negedge Z1);
      check("arb2_gnt", {bus.GNT0, bus.GNT1}, 2'b01);
      check("arb2_track", bus.TRACK, 2);
      watch_access(6000, rd_n, wr_n, fb, fw, db, dw, words, err_v, seen);
      check("arb2_done", {seen, err_v}, 2'b10);
      bus.REQ1 = 1'b0;
      bus.ADR0 = 7'((smp_word + 3) % 128);
      repeat (2) @(negedge Z1);
      check("arb3_gnt", {bus.GNT0, bus.GNT1}, 2'b10);
      watch_access(6000, rd_n, wr_n, fb, fw, db, dw, words, err_v, seen);
      check("arb3_done", seen, 1);
      bus.REQ0 = 1'b0;
      repeat (2) @(negedge Z1);

      // Read track 5 word 17
      bus.TRK0 = 5'd5; bus.ADR0 = 7'd17; bus.WR0 = 1'b0; bus.REQ0 = 1'b1;
      @(negedge Z1);
      check("rd_gnt", {bus.GNT0, bus.GNT1}, 2'b10);
      check("rd_track", bus.TRACK, 5);
      watch_access(6000, rd_n, wr_n, fb, fw, db, dw, words, err_v, seen);
      check("rd_done", seen, 1);
      check("rd_err", err_v, 0);
      check("rd_gate_len", rd_n, 40);
      check("rd_wr_gate", wr_n, 0);
      check("rd_first_bit", fb, 0);
      check("rd_first_word", fw, 17);
      check("rd_gnt_at_done", bus.GNT0, 1);
      bus.REQ0 = 1'b0;
      @(negedge Z1);
      check("rd_after", {bus.DONE, bus.GNT0}, 2'b00);
      @(negedge Z1);

      // Write refused (REQ1 dropped early, access must still complete)
      bus.W1 = 1'b0;
      bus.TRK1 = 5'd9; bus.ADR1 = 7'd40; bus.WR1 = 1'b1; bus.REQ1 = 1'b1;
      @(negedge Z1);
      check("wf_gnt", {bus.GNT0, bus.GNT1}, 2'b01);
      bus.REQ1 = 1'b0;
      watch_access(6000, rd_n, wr_n, fb, fw, db, dw, words, err_v, seen);
      check("wf_done", seen, 1);
      check("wf_err", err_v, 1);
      check("wf_gates", rd_n + wr_n, 0);
      check("wf_done_word", dw, 40);
      check("wf_done_bit", db, 0);
      bus.W1 = 1'b1; bus.WR1 = 1'b0;
      repeat (2) @(negedge Z1);

      // Timeout: sector track never shows the requested address
      z3_bad = 1'b1;
      repeat (45) @(negedge Z1);
      bus.TRK0 = 5'd3; bus.ADR0 = 7'd3; bus.REQ0 = 1'b1;
      @(negedge Z1);
      check("to_gnt", bus.GNT0, 1);
      watch_access(6000, rd_n, wr_n, fb, fw, db, dw, words, err_v, seen);
      check("to_done", seen, 1);
      check("to_err", err_v, 1);
      check("to_words", words, 129);
      check("to_gates", rd_n + wr_n, 0);
      bus.REQ0 = 1'b0;
      z3_bad = 1'b0;
      repeat (45) @(negedge Z1);

      // Clear asserted at phase 20 of a read transfer
      bus.TRK0 = 5'd7; bus.ADR0 = 7'((smp_word + 3) % 128); bus.REQ0 = 1'b1;
      @(negedge Z1);
      check("cx_gnt", bus.GNT0, 1);
      got = 1'b0;
      for (int i = 0; i < 6000 && !got; i++) begin
         @(negedge Z1);
         if (bus.RD_GATE && (bus.BITIDX == 6'd20)) got = 1'b1;
      end
      check("cx_reached", got, 1);
      CLR = 1'b0;
      #1;
      check("cx_gates", {bus.RD_GATE, bus.WR_GATE}, 2'b00);
      check("cx_lock_gnt", {bus.LOCK, bus.GNT0, bus.DONE}, 3'b000);
      bus.REQ0 = 1'b0;
      @(negedge Z1);
      CLR = 1'b1;
      dn = 0; early = 0; got = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge Z1);
         if (bus.DONE) dn++;
         if (smp_bit == 0) begin
            got = 1'b1;
            check("cx_relock", bus.LOCK, 1);
         end else if (bus.LOCK) begin
            early++;
         end
      end
      check("cx_wordstart", got, 1);
      check("cx_no_done", dn, 0);
      check("cx_lock_early", early, 0);

      check("no_overlap", excl_viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/drum_access_sequencer.md
DRUM_ACCESS_SEQUENCER -- requirements
Module: drum_access_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: Z1 (bit clock, one rising edge per drum bit time) and CLR (active-low, asynchronous).
REQ-002 SHALL provide ports (name  direction  width  meaning):
- Z1  in  1  bit clock
- CLR  in  1  async active-low clear
- Z2  in  1  word-marker track (high bits 31-33 and 38-39 of each 40-bit word)
- Z3  in  1  serial sector-address track (address LSB-first in bits 32-38)
- W1  in  1  write permitted (drum ready)
- REQ0, REQ1  in  1 each  access request, level, held until DONE
- TRK0, TRK1  in  5 each  requested track
- ADR0, ADR1  in  7 each  requested word address
- WR0, WR1  in  1 each  1=write, 0=read
- GNT0, GNT1  out  1 each  requester owns the drum
- DONE  out  1  one-cycle completion pulse to the granted requester
- ERR  out  1  valid with DONE: timeout or write refused
- TRACK  out  5  head-select to drum
- RD_GATE, WR_GATE  out  1 each  transfer gates
- BITIDX  out  6  bit index 0-39 within the current word
- LOCK  out  1  word timing synchronised

Function
REQ-003 SHALL sample all inputs on the rising edge of Z1; all state SHALL update on that edge.
REQ-004 SHALL count consecutive high Z2 samples; a high run of exactly 2 followed by a low sample SHALL define that low cycle as bit 0 of a new word.
REQ-005 SHALL hold a 6-bit phase counter that advances 0..39 and wraps 39->0; a word-start detection SHALL force it to 0 and set LOCK.
REQ-006 SHALL clear LOCK when a word start is detected while the phase counter is not at 39 (resync) and SHALL load the phase to 0 in that same cycle.
REQ-007 SHALL shift Z3 into a 7-bit register LSB-first during phases 32-38; at phase 39 the register value names the word beginning at the next phase 0.
REQ-008 SHALL implement states IDLE, SEEK, XFER, FINISH.
REQ-009 IDLE: if exactly one REQx is high, grant it; if both are high, grant the requester not granted last (round-robin); the grant SHALL take effect the next cycle.
REQ-010 On grant, SHALL latch TRKx, ADRx and WRx, assert GNTx, drive TRACK from the latched track, clear the timeout counter, and enter SEEK.
REQ-011 SEEK: at phase 39 with LOCK=1, if the sector register equals the latched address, SHALL enter XFER; otherwise it SHALL increment an 8-bit word timeout counter.
REQ-012 SEEK: when the timeout counter reaches 129 words, SHALL enter FINISH with ERR=1.
REQ-013 At XFER entry for a write with W1=0, SHALL enter FINISH with ERR=1 and no WR_GATE pulse.
REQ-014 XFER: SHALL assert RD_GATE (read) or WR_GATE (write) for exactly 40 cycles, phases 0-39, then enter FINISH with ERR=0.
REQ-015 XFER: if LOCK drops, SHALL deassert the gates immediately and enter FINISH with ERR=1.
REQ-016 FINISH: SHALL pulse DONE for one cycle with ERR valid, drop GNTx in the following cycle, update the round-robin pointer, and return to IDLE.
REQ-017 SHALL ignore REQx deassertion while granted; the access completes normally.
REQ-018 SHALL never assert GNT0 and GNT1 together, nor RD_GATE and WR_GATE together.
REQ-019 BITIDX SHALL equal the phase counter at all times.

Reset
REQ-020 CLR low SHALL immediately force: state IDLE; GNT0/GNT1, DONE, ERR, RD_GATE, WR_GATE, LOCK = 0; TRACK = 0; BITIDX = 0; sector register = 0; timeout counter = 0; round-robin pointer favouring REQ0.
REQ-021 CLR asserted mid-XFER SHALL drop the gates asynchronously with no DONE pulse; after release, LOCK SHALL be reacquired only via REQ-004.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Word-sync: nominal Z2/Z3 pattern -> LOCK=1 after the first word start, BITIDX 0 in the cycle after the second Z2 high bit.
- Read: REQ0, TRK0=5, ADR0=17, WR0=0 -> TRACK=5; RD_GATE high for 40 cycles starting at phase 0 of word 17; then DONE=1, ERR=0.
- Arbitration: REQ0 and REQ1 raised in the same cycle after reset -> GNT0 first, then GNT1; a repeat simultaneous request -> GNT1 first.
- Write refused: WR1=1, W1=0 -> DONE with ERR=1 at word match, WR_GATE never high.
- Timeout: Z3 never presents the requested address -> DONE with ERR=1 after 129 words.
- Reset: CLR pulsed low at phase 20 of an XFER -> gates drop immediately, no DONE, LOCK=0 until the next word start.
